// File: rtl/button_debounce_pkg.sv
// Shared FSM encodings, default timing constants and counter sizing for the button debouncer.
// Imported by the interface, the top level and the per-button channel.
package button_debounce_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE  = 2'd0,
    BTN_DELAY = 2'd1,
    BTN_RPT   = 2'd2
  } btn_state_t;

  localparam int N_BTN_DEF          = 5;
  localparam int STABLE_SAMPLES_DEF = 4;
  localparam int REPEAT_DELAY_DEF   = 50;
  localparam int REPEAT_PERIOD_DEF  = 10;

  // Wide enough to hold the larger of the two repeat intervals without wrapping.
  function automatic int cnt_width(input int delay, input int period);
    return $clog2(((delay > period) ? delay : period) + 1);
  endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Button bundle: raw inputs plus 100Hz sample wave in, debounced level and pulses out.
// master drives raw buttons and the sample wave; slave (the debouncer) drives the results.
interface button_debounce_if
  import button_debounce_pkg::*;
#(
  parameter int N_BTN = N_BTN_DEF
) ();

  logic             clk_100Hz;
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_repeat;

  modport master (
    output clk_100Hz, btn_raw,
    input  btn_level, btn_press, btn_release, btn_repeat
  );

  modport slave (
    input  clk_100Hz, btn_raw,
    output btn_level, btn_press, btn_release, btn_repeat
  );

endinterface

// File: rtl/button_debounce_channel.sv
// One debounced button: sample history, level, press/release pulses and auto-repeat FSM.
// Level changes on the sample_en that completes a run of equal samples; pulses last one clk, no backpressure.
module button_channel
  import button_debounce_pkg::*;
#(
  parameter int STABLE_SAMPLES = STABLE_SAMPLES_DEF,
  parameter int REPEAT_DELAY   = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD  = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic btn_sync,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int            CW       = cnt_width(REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DELAY_C  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] PERIOD_C = CW'(REPEAT_PERIOD);

  logic [STABLE_SAMPLES-1:0] hist, hist_nx;
  logic                      level_nx, press_nx, release_nx, repeat_nx;
  btn_state_t                state, state_nx;
  logic [CW-1:0]             cnt, cnt_nx, cnt_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist        <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_repeat  <= 1'b0;
      state       <= BTN_IDLE;
      cnt         <= '0;
    end else begin
      hist        <= hist_nx;
      btn_level   <= level_nx;
      btn_press   <= press_nx;
      btn_release <= release_nx;
      btn_repeat  <= repeat_nx;
      state       <= state_nx;
      cnt         <= cnt_nx;
    end
  end

  always_comb begin
    hist_nx    = hist;
    level_nx   = btn_level;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    repeat_nx  = 1'b0;
    state_nx   = state;
    cnt_nx     = cnt;
    cnt_inc    = cnt + CW'(1);

    // The level decision looks at the history including the bit shifted in this cycle.
    if (sample_en) begin
      hist_nx = (hist << 1) | STABLE_SAMPLES'(btn_sync);
      if (&hist_nx && !btn_level) begin
        level_nx = 1'b1;
        press_nx = 1'b1;
      end else if (~|hist_nx && btn_level) begin
        level_nx   = 1'b0;
        release_nx = 1'b1;
      end
    end

    case (state)
      BTN_IDLE: begin
        if (press_nx) begin
          state_nx = BTN_DELAY;
          cnt_nx   = '0;
        end
      end
      BTN_DELAY: begin
        if (sample_en) begin
          if (cnt_inc == DELAY_C) begin
            repeat_nx = 1'b1;
            cnt_nx    = '0;
            state_nx  = BTN_RPT;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
      end
      BTN_RPT: begin
        if (sample_en) begin
          if (cnt_inc == PERIOD_C) begin
            repeat_nx = 1'b1;
            cnt_nx    = '0;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
      end
      default: begin
        state_nx = BTN_IDLE;
        cnt_nx   = '0;
      end
    endcase

    // Release wins over a repeat falling on the same sample.
    if (release_nx) begin
      state_nx  = BTN_IDLE;
      cnt_nx    = '0;
      repeat_nx = 1'b0;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Debounces N_BTN raw buttons on the rising edge of a synchronised 100Hz wave; clk_100Hz is data only.
// Sync adds 2 clks before a sample strobe; outputs are registered one clk after the strobe, no backpressure.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int N_BTN          = N_BTN_DEF,
  parameter int STABLE_SAMPLES = STABLE_SAMPLES_DEF,
  parameter int REPEAT_DELAY   = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD  = REPEAT_PERIOD_DEF
) (
  input logic         clk,
  input logic         rst,
  button_debounce_if.slave bus
);

  logic [1:0]       clk_sync;
  logic             clk_prev;
  logic [N_BTN-1:0] raw_s0, raw_s1;
  logic             sample_en;
  logic [N_BTN-1:0] level_v, press_v, release_v, repeat_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= 2'b00;
      clk_prev <= 1'b0;
      raw_s0   <= '0;
      raw_s1   <= '0;
    end else begin
      clk_sync <= {clk_sync[0], bus.clk_100Hz};
      clk_prev <= clk_sync[1];
      raw_s0   <= bus.btn_raw;
      raw_s1   <= raw_s0;
    end
  end

  // Buttons and the sample wave share the same sync depth, so a raw change
  // launched with a 100Hz rising edge is seen by that edge's strobe.
  assign sample_en = clk_sync[1] & ~clk_prev;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_channel #(
      .STABLE_SAMPLES (STABLE_SAMPLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .sample_en   (sample_en),
      .btn_sync    (raw_s1[i]),
      .btn_level   (level_v[i]),
      .btn_press   (press_v[i]),
      .btn_release (release_v[i]),
      .btn_repeat  (repeat_v[i])
    );
  end

  assign bus.btn_level   = level_v;
  assign bus.btn_press   = press_v;
  assign bus.btn_release = release_v;
  assign bus.btn_repeat  = repeat_v;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: sample-level reference model feeding a cycle-stamped scoreboard,
// plus a table of hold patterns with hand-computed level and pulse counts.
module tb_button_debounce;

  localparam int NB = 5;
  localparam int SS = 4;
  localparam int RD = 50;
  localparam int RP = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  button_debounce_if #(.N_BTN(NB)) bus ();

  button_debounce #(
    .N_BTN(NB), .STABLE_SAMPLES(SS), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int          due;
    logic [NB-1:0] lvl;
    logic [NB-1:0] prs;
    logic [NB-1:0] rel;
    logic [NB-1:0] rpt;
  } exp_t;

  typedef struct {
    logic [NB-1:0] raw;
    int          n;
    logic [NB-1:0] lvl;
    int          prs;
    int          rel;
    int          rpt;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[16];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   run_m[NB];
  logic last_m[NB];
  logic lev_m[NB];
  int   held_m[NB];
  logic [NB-1:0] exp_lvl;
  int n_prs = 0, n_rel = 0, n_rpt = 0;
  int p0, r0, t0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      run_m[i]  = SS;
      last_m[i] = 1'b0;
      lev_m[i]  = 1'b0;
      held_m[i] = -1;
    end
    sb.delete();
    exp_lvl = '0;
  endtask

  // Spec-level view: run length of equal samples, ticks held since press.
  task automatic model_sample(input logic [NB-1:0] raw, input int due);
    exp_t e;
    e.due = due; e.lvl = '0; e.prs = '0; e.rel = '0; e.rpt = '0;
    for (int i = 0; i < NB; i++) begin
      if (raw[i] == last_m[i]) run_m[i]++;
      else begin
        run_m[i]  = 1;
        last_m[i] = raw[i];
      end
      if (run_m[i] >= SS && raw[i] && !lev_m[i]) begin
        lev_m[i] = 1'b1; held_m[i] = 0; e.prs[i] = 1'b1;
      end else if (run_m[i] >= SS && !raw[i] && lev_m[i]) begin
        lev_m[i] = 1'b0; held_m[i] = -1; e.rel[i] = 1'b1;
      end else if (lev_m[i]) begin
        held_m[i]++;
        if (held_m[i] >= RD && ((held_m[i] - RD) % RP) == 0) e.rpt[i] = 1'b1;
      end
      e.lvl[i] = lev_m[i];
    end
    sb.push_back(e);
  endtask

  task automatic check_cycle();
    logic [NB-1:0] ep, er, et;
    exp_t e;
    ep = '0; er = '0; et = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      exp_lvl = e.lvl;
      ep = e.prs; er = e.rel; et = e.rpt;
    end
    chk($sformatf("cycle%0d lvl_prs_rel_rpt", cyc),
        {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_repeat},
        {exp_lvl, ep, er, et});
    n_prs += $countones(bus.btn_press);
    n_rel += $countones(bus.btn_release);
    n_rpt += $countones(bus.btn_repeat);
  endtask

  task automatic step();
    @(posedge clk);
    #3;
    check_cycle();
    @(negedge clk);
  endtask

  // One 16-clk period of the 100Hz wave; raw changes launch with its rising edge.
  task automatic sample(input logic [NB-1:0] raw);
    bus.clk_100Hz = 1'b1;
    bus.btn_raw   = raw;
    model_sample(raw, cyc + 3);
    repeat (8) step();
    bus.clk_100Hz = 1'b0;
    repeat (8) step();
  endtask

  initial begin
    //            raw        n   level      prs rel rpt
    vecs[0]  = '{5'b00000,  4, 5'b00000,   0,  5,  0};
    vecs[1]  = '{5'b00001,  3, 5'b00000,   0,  0,  0};
    vecs[2]  = '{5'b00001,  1, 5'b00001,   1,  0,  0};
    vecs[3]  = '{5'b00000,  4, 5'b00000,   0,  1,  0};
    vecs[4]  = '{5'b00010,  1, 5'b00000,   0,  0,  0};
    vecs[5]  = '{5'b00000,  1, 5'b00000,   0,  0,  0};
    vecs[6]  = '{5'b00010,  2, 5'b00000,   0,  0,  0};
    vecs[7]  = '{5'b00000,  1, 5'b00000,   0,  0,  0};
    vecs[8]  = '{5'b00010,  3, 5'b00000,   0,  0,  0};
    vecs[9]  = '{5'b00010,  1, 5'b00010,   1,  0,  0};
    vecs[10] = '{5'b00000,  4, 5'b00000,   0,  1,  0};
    vecs[11] = '{5'b00100, 80, 5'b00100,   1,  0,  3};
    vecs[12] = '{5'b00000,  3, 5'b00100,   0,  0,  0};
    vecs[13] = '{5'b00000,  1, 5'b00000,   0,  1,  0};
    vecs[14] = '{5'b10101,  4, 5'b10101,   3,  0,  0};
    vecs[15] = '{5'b00000,  4, 5'b00000,   0,  3,  0};

    bus.clk_100Hz = 1'b0;
    bus.btn_raw   = '0;
    model_reset();
    #2 rst = 1'b1;
    @(negedge clk);
    repeat (3) step();
    rst = 1'b0;

    // Hold everything, then reset in the middle of a high sample phase.
    p0 = n_prs;
    repeat (6) sample(5'b11111);
    chk("hold_all_level", bus.btn_level, 5'b11111);
    chk("hold_all_presses", n_prs - p0, 5);

    bus.clk_100Hz = 1'b1;
    model_sample(5'b11111, cyc + 3);
    repeat (4) step();
    rst = 1'b1;
    #1;
    chk("reset_async_outputs",
        {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_repeat}, 0);
    model_reset();
    repeat (3) step();

    // Release with the 100Hz wave already high: that counts as the first new sample.
    p0 = n_prs; r0 = n_rel;
    rst = 1'b0;
    model_sample(5'b11111, cyc + 3);
    repeat (4) step();
    bus.clk_100Hz = 1'b0;
    repeat (8) step();
    repeat (2) sample(5'b11111);
    chk("post_reset_level_3samples", bus.btn_level, 5'b00000);
    chk("post_reset_no_pulse", (n_prs - p0) + (n_rel - r0), 0);
    sample(5'b11111);
    chk("post_reset_level_4samples", bus.btn_level, 5'b11111);
    chk("post_reset_presses", n_prs - p0, 5);

    for (int k = 0; k < 16; k++) begin
      p0 = n_prs; r0 = n_rel; t0 = n_rpt;
      repeat (vecs[k].n) sample(vecs[k].raw);
      chk($sformatf("vec%0d_level", k), bus.btn_level, vecs[k].lvl);
      chk($sformatf("vec%0d_press_cnt", k), n_prs - p0, vecs[k].prs);
      chk($sformatf("vec%0d_release_cnt", k), n_rel - r0, vecs[k].rel);
      chk($sformatf("vec%0d_repeat_cnt", k), n_rpt - t0, vecs[k].rpt);
    end

    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
